pe_noc_interface: RTL
=====================

Name: pe_noc_interface

Overview:
- PE-side network interface; attaches to the router's local (L) port, in the opposite direction from the router.
- Injection path: accepts PE requests, stamps source ID and timestamp, and drives 40-bit packets into the router's local input (data/valid with full backpressure).
- Ejection path: receives packets from the router's local output, checks the destination, computes network latency, and buffers packets for the PE under a valid/ready handshake.

Parameters:
- DATASIZE, 40, packet width; layout fixed as src[39:36], dst[35:32], timestamp[31:24], data[23:2], type[1:0].
- INJ_DEPTH, 4, injection FIFO entries (power of 2, ≥2).
- EJ_DEPTH, 4, ejection FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  reset; synchronous, active-low.
- ID  in  4  this node's address.
- req_valid  in  1  PE injection request.
- req_ready  out  1  injection FIFO can accept.
- req_dst  in  4  destination node.
- req_type  in  2  packet type.
- req_data  in  22  payload.
- noc_data_out  out  DATASIZE  packet to router L_data_in.
- noc_valid_out  out  1  packet valid to router L_valid_in.
- noc_full_in  in  1  router local input FIFO full.
- noc_data_in  in  DATASIZE  packet from router L_data_out.
- noc_valid_in  in  1  router L_valid_out.
- noc_full_out  out  1  ejection backpressure to router L_full_in.
- rsp_valid  out  1  ejected packet available.
- rsp_ready  in  1  PE consumes packet.
- rsp_src  out  4  source node of head packet.
- rsp_type  out  2  type of head packet.
- rsp_data  out  22  payload of head packet.
- rsp_latency  out  8  (arrival ts − packet ts) mod 256.
- tx_count  out  16  packets injected; wraps.
- rx_count  out  16  packets delivered to PE; wraps.
- misroute_count  out  8  packets with dst≠ID; saturates at 255.
- err_overflow  out  1  sticky: packet arrived while ejection FIFO full.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - ts, all counters, FIFO pointers and err_overflow cleared.
  - noc_valid_out=0, noc_data_out=0.
  - req_ready is gated to 0 while rst_n=0.
  - noc_full_out=0 and rsp_valid=0 (both FIFOs empty).
  - Reset mid-operation discards all queued packets and does not complete in-flight handshakes.
- Timestamp ts: 8-bit free-running counter, +1 every cycle, wraps 255→0.
- Injection acceptance:
  - A request is accepted on a cycle where req_valid&&req_ready.
  - req_ready = (inj_count<INJ_DEPTH) && rst_n. There is no bypass: with the FIFO full, req_ready=0 even if a pop occurs that cycle.
  - The packet {ID, req_dst, ts, req_data, req_type} is formed with ts sampled at acceptance.
  - dst==ID is legal and injected normally.
- Injection send stage:
  - At each edge, if the FIFO is non-empty and noc_full_in==0: pop the head into the noc_data_out register and set noc_valid_out=1.
  - Otherwise noc_valid_out=0 and noc_data_out holds its value.
  - Every cycle with noc_valid_out=1 is one transfer; throughput is 1 packet/cycle.
  - Latency: accepted at edge k → noc_valid_out high after edge k+1.
  - Simultaneous push and pop are both honoured.
  - tx_count += 1 per cycle with noc_valid_out=1.
- Ejection receive:
  - Every cycle with noc_valid_in=1 is a transfer and must be consumed that cycle.
  - If dst≠ID: drop; misroute_count saturating +1.
  - Else, if the ejection FIFO is not full: push {src, type, data, (ts − pkt_ts)[7:0]}.
  - Else: drop and set err_overflow (cleared only by reset).
- noc_full_out = (ej_count ≥ EJ_DEPTH−1), decoded from registered occupancy. This gives one slot of slack for the router's registered response.
- PE delivery:
  - Ejection FIFO is first-word-fall-through; rsp_valid = ej_count≠0, and the rsp_* fields show the head entry.
  - Pop on rsp_valid&&rsp_ready; rx_count += 1 per pop.
  - Simultaneous push and pop on a full FIFO: the arriving packet is dropped (full is evaluated before the pop).

Test Plan:
- Format check: ID=5, ts=0x10, req dst=0xA, data=0x12345, type=1 → noc_data_out=40'h5A10048D15 with noc_valid_out high 2 edges after acceptance; tx_count=1.
- Backpressure: noc_full_in=1 held; 6 requests offered → 4 accepted, then req_ready=0 and noc_valid_out=0 throughout. Release → 4 consecutive valid cycles in FIFO order; tx_count=4; req_ready returns to 1.
- Latency wrap: inject at router side dst=5, ts field 0xF0, arriving when ts=0x05 → rsp_valid=1, rsp_latency=0x15, src/type/data match.
- Ejection fill: rsp_ready=0, 3 packets → noc_full_out=1 after 3rd; 4th stored; 5th → err_overflow=1, FIFO unchanged. Then rsp_ready=1 → 4 pops in order, rx_count=4, noc_full_out drops when count<3.
- Misroute: 300 packets with dst=3, ID=5 → no rsp_valid, misroute_count=255 (saturated).
- Mid-op reset: 3 queued each way, rst_n=0 one cycle → all outputs at reset values next cycle, nothing emitted afterward, counters 0.

Source files
------------

// File: rtl/pe_noc_interface.sv
// PE-side network interface for a router's local port: stamps and queues PE
// requests toward the router, and checks, timestamps and buffers ejected packets.
module pe_noc_interface #(
    parameter int DATASIZE  = 40,
    parameter int INJ_DEPTH = 4,
    parameter int EJ_DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          ID,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [3:0]          req_dst,
    input  logic [1:0]          req_type,
    input  logic [21:0]         req_data,
    output logic [DATASIZE-1:0] noc_data_out,
    output logic                noc_valid_out,
    input  logic                noc_full_in,
    input  logic [DATASIZE-1:0] noc_data_in,
    input  logic                noc_valid_in,
    output logic                noc_full_out,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [3:0]          rsp_src,
    output logic [1:0]          rsp_type,
    output logic [21:0]         rsp_data,
    output logic [7:0]          rsp_latency,
    output logic [15:0]         tx_count,
    output logic [15:0]         rx_count,
    output logic [7:0]          misroute_count,
    output logic                err_overflow
);
    localparam int INJ_AW = $clog2(INJ_DEPTH);
    localparam int EJ_AW  = $clog2(EJ_DEPTH);
    localparam logic [INJ_AW:0] INJ_MAX  = (INJ_AW+1)'(INJ_DEPTH);
    localparam logic [EJ_AW:0]  EJ_MAX   = (EJ_AW+1)'(EJ_DEPTH);
    localparam logic [EJ_AW:0]  EJ_ALMOST = (EJ_AW+1)'(EJ_DEPTH - 1);

    logic [7:0]          ts_q, ts_d;
    logic [INJ_AW-1:0]   inj_wr_q, inj_wr_d, inj_rd_q, inj_rd_d;
    logic [INJ_AW:0]     inj_count_q, inj_count_d;
    logic                noc_valid_q, noc_valid_d;
    logic [DATASIZE-1:0] noc_data_q, noc_data_d;
    logic [15:0]         tx_count_q, tx_count_d;
    logic [EJ_AW-1:0]    ej_wr_q, ej_wr_d, ej_rd_q, ej_rd_d;
    logic [EJ_AW:0]      ej_count_q, ej_count_d;
    logic [15:0]         rx_count_q, rx_count_d;
    logic [7:0]          misroute_q, misroute_d;
    logic                err_overflow_q, err_overflow_d;

    logic [DATASIZE-1:0] inj_mem [INJ_DEPTH];
    logic [35:0]         ej_mem  [EJ_DEPTH];

    logic                inj_push, inj_pop, ej_hit, ej_push, ej_pop;
    logic [DATASIZE-1:0] inj_pkt;
    logic [35:0]         ej_entry;

    assign req_ready = (inj_count_q < INJ_MAX) && rst_n;
    assign inj_push  = req_valid && req_ready;
    assign inj_pop   = (inj_count_q != '0) && !noc_full_in;
    assign inj_pkt   = {ID, req_dst, ts_q, req_data, req_type};

    // Full is judged on registered occupancy, so a pop in the same cycle never frees room.
    assign ej_hit   = noc_valid_in && (noc_data_in[35:32] == ID);
    assign ej_push  = ej_hit && (ej_count_q != EJ_MAX);
    assign ej_pop   = (ej_count_q != '0) && rsp_ready;
    assign ej_entry = {noc_data_in[39:36], noc_data_in[1:0], noc_data_in[23:2],
                       ts_q - noc_data_in[31:24]};

    always_comb begin
        ts_d           = ts_q + 8'd1;
        inj_wr_d       = inj_wr_q;
        inj_rd_d       = inj_rd_q;
        inj_count_d    = inj_count_q;
        noc_valid_d    = inj_pop;
        noc_data_d     = noc_data_q;
        tx_count_d     = tx_count_q + {15'd0, noc_valid_q};
        ej_wr_d        = ej_wr_q;
        ej_rd_d        = ej_rd_q;
        ej_count_d     = ej_count_q;
        rx_count_d     = rx_count_q;
        misroute_d     = misroute_q;
        err_overflow_d = err_overflow_q;

        if (inj_push) inj_wr_d = inj_wr_q + 1'b1;
        if (inj_pop) begin
            inj_rd_d   = inj_rd_q + 1'b1;
            noc_data_d = inj_mem[inj_rd_q];
        end
        case ({inj_push, inj_pop})
            2'b10:   inj_count_d = inj_count_q + 1'b1;
            2'b01:   inj_count_d = inj_count_q - 1'b1;
            default: inj_count_d = inj_count_q;
        endcase

        if (noc_valid_in && !ej_hit && misroute_q != 8'hFF) misroute_d = misroute_q + 8'd1;
        if (ej_hit && !ej_push) err_overflow_d = 1'b1;
        if (ej_push) ej_wr_d = ej_wr_q + 1'b1;
        if (ej_pop) begin
            ej_rd_d    = ej_rd_q + 1'b1;
            rx_count_d = rx_count_q + 16'd1;
        end
        case ({ej_push, ej_pop})
            2'b10:   ej_count_d = ej_count_q + 1'b1;
            2'b01:   ej_count_d = ej_count_q - 1'b1;
            default: ej_count_d = ej_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_q           <= '0;
            inj_wr_q       <= '0;
            inj_rd_q       <= '0;
            inj_count_q    <= '0;
            noc_valid_q    <= 1'b0;
            noc_data_q     <= '0;
            tx_count_q     <= '0;
            ej_wr_q        <= '0;
            ej_rd_q        <= '0;
            ej_count_q     <= '0;
            rx_count_q     <= '0;
            misroute_q     <= '0;
            err_overflow_q <= 1'b0;
        end else begin
            ts_q           <= ts_d;
            inj_wr_q       <= inj_wr_d;
            inj_rd_q       <= inj_rd_d;
            inj_count_q    <= inj_count_d;
            noc_valid_q    <= noc_valid_d;
            noc_data_q     <= noc_data_d;
            tx_count_q     <= tx_count_d;
            ej_wr_q        <= ej_wr_d;
            ej_rd_q        <= ej_rd_d;
            ej_count_q     <= ej_count_d;
            rx_count_q     <= rx_count_d;
            misroute_q     <= misroute_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    // Storage arrays carry no reset; pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        if (inj_push) inj_mem[inj_wr_q] <= inj_pkt;
        if (ej_push) ej_mem[ej_wr_q] <= ej_entry;
    end

    assign noc_valid_out  = noc_valid_q;
    assign noc_data_out   = noc_data_q;
    assign noc_full_out   = (ej_count_q >= EJ_ALMOST);
    assign rsp_valid      = (ej_count_q != '0);
    assign rsp_src        = ej_mem[ej_rd_q][35:32];
    assign rsp_type       = ej_mem[ej_rd_q][31:30];
    assign rsp_data       = ej_mem[ej_rd_q][29:8];
    assign rsp_latency    = ej_mem[ej_rd_q][7:0];
    assign tx_count       = tx_count_q;
    assign rx_count       = rx_count_q;
    assign misroute_count = misroute_q;
    assign err_overflow   = err_overflow_q;
endmodule
